instqueue_param: RTL
====================

Name: instqueue_param

Overview:
- Parametrised instruction queue between the fetch unit (IF) and the dispatch / reservation-station stage.
- Buffers fetched instructions together with their PC and branch-prediction bit.
- Presents the oldest entry to dispatch with a valid/ready handshake.
- Discards all contents on a ROB flush (mispredict / exception). Successor to the fixed-size instqueue: depth and PC width are configurable, and it adds occupancy reporting and an optional empty-queue bypass.

Parameters:
- XLEN, 32, width of PC field in bits.
- DEPTH, 16, number of entries; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low freezes all state
- if_instqueue_en_in  input  1  IF push request
- if_instqueue_inst_in  input  32  pushed instruction word
- if_instqueue_pc_in  input  XLEN  pushed PC
- if_instqueue_pred_in  input  1  pushed predicted-taken bit
- instqueue_if_rdy_out  output  1  queue can accept a push this cycle (= !full)
- instqueue_rs_en_out  output  1  head entry valid
- instqueue_rs_inst_out  output  32  head instruction
- instqueue_rs_pc_out  output  XLEN  head PC
- instqueue_rs_pred_out  output  1  head predicted-taken bit
- rs_instqueue_rdy_in  input  1  dispatch consumes head this cycle when valid
- rob_instqueue_rst_in  input  1  flush request
- instqueue_cnt_out  output  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Single clock domain. Every state change happens on the clk_in rising edge, and only when rdy_in=1 or rst_in=1.
- Storage: DEPTH-entry array of {inst, pc, pred}. Head and tail pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - empty: head==tail.
  - full: index bits are equal and the wrap bits differ.
- Reset (rst_in=1, takes precedence over rdy_in): head=tail=0.
  - Outputs after reset: instqueue_if_rdy_out=1, instqueue_rs_en_out=0, instqueue_cnt_out=0.
  - Data outputs are don't-care but driven to 0.
  - Array contents need not be cleared.
- rdy_in=0: pointers and array hold. Outputs stay combinational functions of the held state. Push, pop and flush are all ignored.
- push = if_instqueue_en_in && !full. It writes the entry at tail[ADDR_W-1:0] and increments tail (wraps naturally). A push while full is dropped; IF must hold its request until instqueue_if_rdy_out=1.
- pop = instqueue_rs_en_out && rs_instqueue_rdy_in. It increments head.
- Head outputs are a combinational read of array[head] (registered storage, no extra output stage).
- Push-to-visible latency is 1 cycle: an entry pushed at edge N is presented after edge N.
- Simultaneous push and pop:
  - Allowed when neither full nor empty; count is unchanged.
  - When full, no push is accepted, even if a pop occurs in the same cycle.
  - When empty, no pop occurs (en_out=0).
- Flush (rob_instqueue_rst_in=1 with rdy_in=1):
  - Sets head=tail=0 at the edge.
  - Overrides any push or pop in the same cycle; the pushed entry is discarded.
  - In that cycle: instqueue_rs_en_out is forced to 0 combinationally and instqueue_if_rdy_out is forced to 0, so no handshake completes.
- instqueue_cnt_out = tail - head, as an ADDR_W+1-bit modular subtraction; DEPTH when full.
- Reset or flush mid-stream leaves no stale entry visible in the next cycle.

Optional Feature:
- Macro: INSTQ_BYPASS_EN.
- Defined: when the queue is empty, no flush is asserted and if_instqueue_en_in=1, the incoming {inst, pc, pred} is forwarded combinationally to the rs outputs with instqueue_rs_en_out=1.
  - If rs_instqueue_rdy_in=1 in that cycle, the entry is consumed and never written; pointers are unchanged.
  - Otherwise it is written normally and appears from the array next cycle.
- Undefined: there is no combinational path from IF inputs to rs outputs; latency is strictly 1 cycle.

Test Plan:
- Reset, then push 3 instructions (inst 0x00000013/0x00100093/0x00200113, pc 0x0/0x4/0x8) with rs_rdy=0 -> cnt_out=3, head outputs inst 0x00000013, pc 0x0, en_out=1.
- DEPTH=4: push 5 consecutive cycles with no pop -> if_rdy_out=0 after the 4th edge, 5th push dropped, cnt_out=4; pop all 4 -> order pc 0x0,0x4,0x8,0xC, then en_out=0.
- Wrap-around (DEPTH=4): 10 cycles of simultaneous push+pop with a steady occupancy of 2 -> popped PCs strictly sequential, cnt_out constant at 2, no loss or duplication.
- With 3 entries queued, assert flush together with push and rs_rdy=1 -> en_out=0 and if_rdy_out=0 that cycle; next cycle cnt_out=0, en_out=0.
- With 2 entries, hold rdy_in=0 for 5 cycles while toggling push/pop/flush -> cnt_out stays 2 and head pc unchanged; after rdy_in returns to 1, normal operation.
- INSTQ_BYPASS_EN defined, empty queue: push pc 0x100 with rs_rdy=1 -> same cycle en_out=1, pc_out=0x100; next cycle cnt_out=0. Undefined: en_out=0 that cycle, en_out=1 next cycle.

Source files
------------

// File: rtl/instqueue_param.sv
// instqueue_param: IF -> dispatch instruction FIFO of {inst, pc, pred}; optional empty-queue bypass under INSTQ_BYPASS_EN.
// Latency 1 cycle (0 with bypass); IF stalls while if_rdy is low (full/flush), head holds until rs_rdy.
module instqueue_param #(
   parameter int XLEN = 32,
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              if_instqueue_en_in,
   input  logic [31:0]       if_instqueue_inst_in,
   input  logic [XLEN-1:0]   if_instqueue_pc_in,
   input  logic              if_instqueue_pred_in,
   output logic              instqueue_if_rdy_out,
   output logic              instqueue_rs_en_out,
   output logic [31:0]       instqueue_rs_inst_out,
   output logic [XLEN-1:0]   instqueue_rs_pc_out,
   output logic              instqueue_rs_pred_out,
   input  logic              rs_instqueue_rdy_in,
   input  logic              rob_instqueue_rst_in,
   output logic [ADDR_W:0]   instqueue_cnt_out
);

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
      logic            pred;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [ADDR_W:0] head;
   logic [ADDR_W:0] tail;
   logic            empty;
   logic            full;
   logic            flush;
   logic            vld;
   logic            push;
   logic            pop;
   logic            wr;
   logic            byp_take;
   entry_t          in_ent;
   entry_t          head_ent;

   assign in_ent = '{inst: if_instqueue_inst_in, pc: if_instqueue_pc_in, pred: if_instqueue_pred_in};

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty = (head == tail);
   assign full  = (head[ADDR_W-1:0] == tail[ADDR_W-1:0]) && (head[ADDR_W] != tail[ADDR_W]);
   assign flush = rdy_in && rob_instqueue_rst_in;

`ifdef INSTQ_BYPASS_EN
   logic byp;
   assign byp      = rdy_in && empty && !flush && if_instqueue_en_in;
   assign vld      = (!empty || byp) && !flush;
   assign byp_take = byp && rs_instqueue_rdy_in;
   assign head_ent = byp ? in_ent : mem[head[ADDR_W-1:0]];
`else
   assign vld      = !empty && !flush;
   assign byp_take = 1'b0;
   assign head_ent = mem[head[ADDR_W-1:0]];
`endif

   assign push = rdy_in && !flush && if_instqueue_en_in && !full;
   // A bypassed entry consumed in the same cycle never occupies a slot.
   assign wr   = push && !byp_take;
   assign pop  = rdy_in && vld && rs_instqueue_rdy_in && !empty;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head <= '0;
         tail <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (wr)  tail <= tail + (ADDR_W+1)'(1);
            if (pop) head <= head + (ADDR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && wr) mem[tail[ADDR_W-1:0]] <= in_ent;
   end

   assign instqueue_if_rdy_out  = !full && !flush;
   assign instqueue_rs_en_out   = vld;
   assign instqueue_rs_inst_out = vld ? head_ent.inst : '0;
   assign instqueue_rs_pc_out   = vld ? head_ent.pc   : '0;
   assign instqueue_rs_pred_out = vld ? head_ent.pred : 1'b0;
   assign instqueue_cnt_out     = tail - head;

endmodule
